// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters (write and read side).
// Contents: default master count / AWLEN width, QoS field width, and the
// write-arbiter FSM state encoding.
package axi_ic_pkg;

    localparam int unsigned AXI_NUM_M_DEF = 4;
    localparam int unsigned AXI_LEN_W_DEF = 8;
    localparam int unsigned AXI_QOS_W     = 4;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    - per-master request vector
//   ptr    - highest-priority master index for this pick
//   winner - one-hot winner (all zero when req is zero)
module rr_pick #(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] winner
);

    logic found;

    // Scan offsets ptr, ptr+1, ... (mod NUM_M); first requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned d = 0; d < NUM_M; d++) begin
            for (int unsigned i = 0; i < NUM_M; i++) begin
                if (!found && req[i] && (((32'(ptr) + d) % NUM_M) == i)) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// AXI write-channel arbiter: grants one master at a time and steps its
// AW, W and B phases through IDLE -> ADDR -> DATA -> RESP.
// Optional macro AXI_WR_ARB_QOS_EN adds the qos port; the winner is then the
// highest-QoS requester with round-robin tie-break.
// Ports:
//   ACLK, ARESET           - clock, asynchronous active-high reset
//   req, awlen             - per-master AWVALID and AWLEN (slice i = master i)
//   aw_hs, w_hs, wlast     - slave-side AW/W handshakes and WLAST
//   b_hs                   - B handshake toward the granted master
//   qos                    - per-master AWQOS (only with AXI_WR_ARB_QOS_EN)
//   grant, grant_idx       - one-hot and binary grant
//   aw_en, w_en, b_en      - channel route enables
//   busy, len_err          - not-idle flag, WLAST/AWLEN mismatch pulse
module axi_wr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int unsigned NUM_M = AXI_NUM_M_DEF,
    parameter int unsigned LEN_W = AXI_LEN_W_DEF,
    parameter int unsigned IDX_W = $clog2(NUM_M)
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_M-1:0]       req,
    input  logic [NUM_M*LEN_W-1:0] awlen,
    input  logic                   aw_hs,
    input  logic                   w_hs,
    input  logic                   wlast,
    input  logic                   b_hs,
`ifdef AXI_WR_ARB_QOS_EN
    input  logic [NUM_M*AXI_QOS_W-1:0] qos,
`endif
    output logic [NUM_M-1:0]       grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   aw_en,
    output logic                   w_en,
    output logic                   b_en,
    output logic                   busy,
    output logic                   len_err
);

    localparam int unsigned CNT_W = LEN_W + 1;

    wr_arb_state_t    state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             aw_en_q, aw_en_d;
    logic             w_en_q, w_en_d;
    logic             b_en_q, b_en_d;
    logic             busy_q, busy_d;
    logic             len_err_q, len_err_d;

    logic [NUM_M-1:0] pick_req;
    logic [NUM_M-1:0] winner;
    logic [IDX_W-1:0] winner_idx;
    logic [LEN_W-1:0] len_sel;

`ifdef AXI_WR_ARB_QOS_EN
    logic [AXI_QOS_W-1:0] qos_max;

    // Keep only requesters at the highest QoS; round-robin breaks the tie.
    always_comb begin
        qos_max  = '0;
        pick_req = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (req[i] && (qos[i*AXI_QOS_W +: AXI_QOS_W] > qos_max)) begin
                qos_max = qos[i*AXI_QOS_W +: AXI_QOS_W];
            end
        end
        for (int unsigned i = 0; i < NUM_M; i++) begin
            pick_req[i] = req[i] && (qos[i*AXI_QOS_W +: AXI_QOS_W] == qos_max);
        end
    end
`else
    assign pick_req = req;
`endif

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    // One-hot winner to binary index.
    always_comb begin
        winner_idx = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (winner[i]) winner_idx = IDX_W'(i);
        end
    end

    // AWLEN of the granted master.
    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant_idx_q == IDX_W'(i)) len_sel = awlen[i*LEN_W +: LEN_W];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= WR_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            aw_en_q     <= 1'b0;
            w_en_q      <= 1'b0;
            b_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            aw_en_q     <= aw_en_d;
            w_en_q      <= w_en_d;
            b_en_q      <= b_en_d;
            busy_q      <= busy_d;
            len_err_q   <= len_err_d;
        end
    end

    // Next-state logic; output registers are loaded from the next state so
    // every output is a flop.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        len_err_d   = 1'b0;

        case (state_q)
            WR_IDLE: begin
                if (|req) begin
                    grant_d     = winner;
                    grant_idx_d = winner_idx;
                    state_d     = WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_hs) begin
                    len_d      = len_sel;
                    beat_cnt_d = '0;
                    state_d    = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // beat_cnt_q holds the zero-based index of this beat.
                    if (wlast) begin
                        len_err_d = (beat_cnt_q != {1'b0, len_q});
                        state_d   = WR_RESP;
                    end else if (beat_cnt_q == {1'b0, len_q}) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    ptr_d   = (grant_idx_q == IDX_W'(NUM_M - 1)) ? '0
                                                                : grant_idx_q + IDX_W'(1);
                    grant_d = '0;
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase

        aw_en_d = (state_d == WR_ADDR);
        w_en_d  = (state_d == WR_DATA);
        b_en_d  = (state_d == WR_RESP);
        busy_d  = (state_d != WR_IDLE);
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign aw_en     = aw_en_q;
    assign w_en      = w_en_q;
    assign b_en      = b_en_q;
    assign busy      = busy_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: a cycle table of {inputs, expected
// outputs} plus hand-written sequences for round-robin order, mid-burst
// reset and (with AXI_WR_ARB_QOS_EN) QoS priority.
module tb_axi_wr_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic [3:0]  req;
    logic [31:0] awlen;
    logic        aw_hs, w_hs, wlast, b_hs;
`ifdef AXI_WR_ARB_QOS_EN
    logic [15:0] qos;
`endif
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        aw_en, w_en, b_en, busy, len_err;

    int checks   = 0;
    int failures = 0;

    axi_wr_arbiter dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req       (req),
        .awlen     (awlen),
        .aw_hs     (aw_hs),
        .w_hs      (w_hs),
        .wlast     (wlast),
        .b_hs      (b_hs),
`ifdef AXI_WR_ARB_QOS_EN
        .qos       (qos),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .aw_en     (aw_en),
        .w_en      (w_en),
        .b_en      (b_en),
        .busy      (busy),
        .len_err   (len_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        string       nm;
        logic [3:0]  req;
        logic [7:0]  len;
        logic        aw, w, wl, b;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [10:0] e(input logic [3:0] g, input logic [1:0] i,
                                      input logic a, input logic w, input logic b,
                                      input logic bz, input logic er);
        return {g, i, a, w, b, bz, er};
    endfunction

    function automatic logic [10:0] obs();
        return {grant, grant_idx, aw_en, w_en, b_en, busy, len_err};
    endfunction

    task automatic add(input string nm, input logic [3:0] r, input logic [7:0] l,
                       input logic a, input logic w, input logic wl, input logic b,
                       input logic [10:0] x);
        vec_t v;
        v.nm = nm; v.req = r; v.len = l; v.aw = a; v.w = w; v.wl = wl; v.b = b; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; aw_hs = 0; w_hs = 0; wlast = 0; b_hs = 0;
    endtask

    // Full transaction: grant, AW, beats (wlast on last), b_delay idle cycles, B.
    task automatic burst(input logic [3:0] r, input logic [7:0] len, input int beats,
                         input int b_delay, output logic [3:0] g, output logic err);
        err = 1'b0;
        req = r; awlen = {4{len}};
        step();
        g = grant;
        aw_hs = 1; step(); aw_hs = 0;
        for (int k = 0; k < beats; k++) begin
            w_hs = 1; wlast = (k == beats - 1);
            step();
            err = err | len_err;
        end
        w_hs = 0; wlast = 0;
        for (int k = 0; k < b_delay; k++) step();
        b_hs = 1; step(); b_hs = 0;
        err = err | len_err;
    endtask

    logic [3:0] g;
    logic       er;
    logic       any_err;

    initial begin
        // Single master m2, awlen=3, 4 beats, B two cycles after WLAST; stray
        // handshakes in the wrong phase must be ignored.
        add("A0_idle_to_addr",  4'b0100, 8'd3, 0,1,0,1, e(4'b0100,2,1,0,0,1,0));
        add("A1_addr_hold",     4'b0100, 8'd3, 0,1,0,1, e(4'b0100,2,1,0,0,1,0));
        add("A2_aw_req_drop",   4'b0000, 8'd3, 1,0,0,0, e(4'b0100,2,0,1,0,1,0));
        add("A3_data_ign_awb",  4'b0000, 8'd3, 1,0,0,1, e(4'b0100,2,0,1,0,1,0));
        add("A4_beat1",         4'b0000, 8'd3, 0,1,0,0, e(4'b0100,2,0,1,0,1,0));
        add("A5_beat2",         4'b0000, 8'd3, 0,1,0,0, e(4'b0100,2,0,1,0,1,0));
        add("A6_beat3",         4'b0000, 8'd3, 0,1,0,0, e(4'b0100,2,0,1,0,1,0));
        add("A7_beat4_last",    4'b0000, 8'd3, 0,1,1,0, e(4'b0100,2,0,0,1,1,0));
        add("A8_resp_ign_aww",  4'b0000, 8'd3, 1,1,1,0, e(4'b0100,2,0,0,1,1,0));
        add("A9_bhs",           4'b0000, 8'd3, 0,0,0,1, e(4'b0000,2,0,0,0,0,0));
        add("A10_idle",         4'b0000, 8'd3, 0,0,0,0, e(4'b0000,2,0,0,0,0,0));
        // Early WLAST: awlen=7, wlast on beat 5.
        add("B0_grant_m0",      4'b0001, 8'd7, 0,0,0,0, e(4'b0001,0,1,0,0,1,0));
        add("B1_aw",            4'b0001, 8'd7, 1,0,0,0, e(4'b0001,0,0,1,0,1,0));
        add("B2_beat1",         4'b0001, 8'd7, 0,1,0,0, e(4'b0001,0,0,1,0,1,0));
        add("B3_beat2",         4'b0001, 8'd7, 0,1,0,0, e(4'b0001,0,0,1,0,1,0));
        add("B4_beat3",         4'b0001, 8'd7, 0,1,0,0, e(4'b0001,0,0,1,0,1,0));
        add("B5_beat4",         4'b0001, 8'd7, 0,1,0,0, e(4'b0001,0,0,1,0,1,0));
        add("B6_beat5_last",    4'b0001, 8'd7, 0,1,1,0, e(4'b0001,0,0,0,1,1,1));
        add("B7_err_one_cycle", 4'b0001, 8'd7, 0,0,0,0, e(4'b0001,0,0,0,1,1,0));
        add("B8_bhs",           4'b0000, 8'd7, 0,0,0,1, e(4'b0000,0,0,0,0,0,0));
        // Late WLAST: awlen=1, 3 beats.
        add("C0_grant_m1",      4'b0010, 8'd1, 0,0,0,0, e(4'b0010,1,1,0,0,1,0));
        add("C1_aw",            4'b0010, 8'd1, 1,0,0,0, e(4'b0010,1,0,1,0,1,0));
        add("C2_beat1",         4'b0010, 8'd1, 0,1,0,0, e(4'b0010,1,0,1,0,1,0));
        add("C3_beat2_over",    4'b0010, 8'd1, 0,1,0,0, e(4'b0010,1,0,1,0,1,1));
        add("C4_beat3_last",    4'b0010, 8'd1, 0,1,1,0, e(4'b0010,1,0,0,1,1,1));
        add("C5_resp",          4'b0000, 8'd1, 0,0,0,0, e(4'b0010,1,0,0,1,1,0));
        add("C6_bhs",           4'b0000, 8'd1, 0,0,0,1, e(4'b0000,1,0,0,0,0,0));
        // ptr is now 2: all four requesting picks m2.
        add("D0_rr_from_ptr2",  4'b1111, 8'd0, 0,0,0,0, e(4'b0100,2,1,0,0,1,0));

        ARESET = 1'b1; awlen = '0;
        idle_inputs();
`ifdef AXI_WR_ARB_QOS_EN
        qos = '0;
`endif
        step(); step();
        chk("reset_outputs", 32'(obs()), 32'(0));
        ARESET = 1'b0;
        step();
        chk("idle_after_reset", 32'(obs()), 32'(0));

        for (int n = 0; n < tbl.size(); n++) begin
            req = tbl[n].req; awlen = {4{tbl[n].len}};
            aw_hs = tbl[n].aw; w_hs = tbl[n].w; wlast = tbl[n].wl; b_hs = tbl[n].b;
            step();
            chk(tbl[n].nm, 32'(obs()), 32'(tbl[n].exp));
        end
        idle_inputs();

        // Round-robin order from reset with all four requesting.
        ARESET = 1'b1; step(); ARESET = 1'b0;
        any_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            burst(4'b1111, 8'd7, 8, 0, g, er);
            any_err = any_err | er;
            chk($sformatf("rr_order_%0d", k), 32'(g), 32'(4'b0001 << (k % 4)));
        end
        chk("rr_no_len_err", 32'(any_err), 32'(0));
        idle_inputs();
        step();
        chk("rr_idle_after", 32'(busy), 32'(0));

        // Mid-burst reset: m2 completes (ptr -> 3), m3 starts and is reset in DATA.
        burst(4'b0100, 8'd3, 4, 2, g, er);
        chk("pre_m2_grant", 32'(g), 32'(4'b0100));
        idle_inputs(); step();
        req = 4'b1000; awlen = {4{8'd7}};
        step();
        chk("pre_m3_grant", 32'(grant), 32'(4'b1000));
        aw_hs = 1; step(); aw_hs = 0;
        for (int k = 0; k < 3; k++) begin w_hs = 1; step(); end
        chk("pre_reset_data", 32'(w_en), 32'(1));
        #3 ARESET = 1'b1;
        #1 chk("async_reset_outputs", 32'(obs()), 32'(0));
        step();
        ARESET = 1'b0; idle_inputs();
        req = 4'b1010; awlen = '0;
        step();
        chk("post_reset_grant", 32'({grant, grant_idx}), 32'({4'b0010, 2'd1}));
        aw_hs = 1; step(); aw_hs = 0;
        w_hs = 1; wlast = 1; step(); w_hs = 0; wlast = 0;
        chk("post_reset_resp", 32'({b_en, len_err}), 32'(2'b10));
        b_hs = 1; step(); b_hs = 0; req = '0;
        chk("post_reset_done", 32'(busy), 32'(0));

`ifdef AXI_WR_ARB_QOS_EN
        qos = {4'd0, 4'd0, 4'd9, 4'd2};
        step();
        burst(4'b0011, 8'd0, 1, 0, g, er);
        chk("qos_first_m1", 32'(g), 32'(4'b0010));
        burst(4'b0001, 8'd0, 1, 0, g, er);
        chk("qos_then_m0", 32'(g), 32'(4'b0001));
        idle_inputs();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
